// File: rtl/hazard_detection_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detection_unit
// Description : Load-use stall / branch flush / memory-hold controller with
//               saturating event counters for a 5-stage pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detection_unit #(
   parameter int CNT_W = 16,
   parameter int REG_W = 5
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             branch_taken,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             pipe_freeze,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_stall_count;
   logic [CNT_W-1:0] r_flush_count;
   logic             w_load_use;
   logic             w_stall_inc;
   logic             w_flush_inc;

   assign w_load_use = ex_mem_read && (ex_rt != '0) &&
                       ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= RUN;
         r_stall_count <= '0;
         r_flush_count <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_stall_inc && (r_stall_count != c_cnt_max))
            r_stall_count <= r_stall_count + c_cnt_one;
         if (w_flush_inc && (r_flush_count != c_cnt_max))
            r_flush_count <= r_flush_count + c_cnt_one;
      end
   end

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      pipe_freeze  = 1'b0;
      w_next_state = RUN;
      w_stall_inc  = 1'b0;
      w_flush_inc  = 1'b0;

      if (!reset_n) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
      end else if (mem_busy) begin
         // Whole pipeline holds; an out-of-range state still recovers to RUN.
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         pipe_freeze = 1'b1;
         case (r_state)
            STALL:   w_next_state = STALL;
            FLUSH:   w_next_state = FLUSH;
            default: w_next_state = RUN;
         endcase
      end else begin
         case (r_state)
            STALL: begin
               if (branch_taken) begin
                  if_id_flush  = 1'b1;
                  id_ex_bubble = 1'b1;
                  w_next_state = FLUSH;
                  w_flush_inc  = 1'b1;
               end
            end
            FLUSH: begin
               // EX holds a squashed bubble, so its branch/load info is stale.
               w_next_state = RUN;
            end
            default: begin
               if (branch_taken) begin
                  if_id_flush  = 1'b1;
                  id_ex_bubble = 1'b1;
                  w_next_state = FLUSH;
                  w_flush_inc  = 1'b1;
               end else if (w_load_use) begin
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_bubble = 1'b1;
                  w_next_state = STALL;
                  w_stall_inc  = 1'b1;
               end
            end
         endcase
      end
   end

   assign state       = r_state;
   assign stall_count = r_stall_count;
   assign flush_count = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_detection_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_detection_unit
// Description : Table-driven self-checking bench for hazard_detection_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_detection_unit;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
   logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0;
   logic       branch_taken = 1'b0, mem_busy = 1'b0;

   logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze;
   logic [1:0]  state;
   logic [15:0] stall_count, flush_count;

   logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_pipe_freeze;
   logic [1:0]  s_state;
   logic [1:0]  s_stall_count, s_flush_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   hazard_detection_unit #(.CNT_W(16), .REG_W(5)) u_dut (
      .clock(clock), .reset_n(reset_n),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .branch_taken(branch_taken), .mem_busy(mem_busy),
      .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
      .id_ex_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze),
      .state(state), .stall_count(stall_count), .flush_count(flush_count)
   );

   hazard_detection_unit #(.CNT_W(2), .REG_W(5)) u_sat (
      .clock(clock), .reset_n(reset_n),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .branch_taken(branch_taken), .mem_busy(mem_busy),
      .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
      .id_ex_bubble(s_id_ex_bubble), .pipe_freeze(s_pipe_freeze),
      .state(s_state), .stall_count(s_stall_count), .flush_count(s_flush_count)
   );

   // Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze}
   localparam logic [4:0] c_def   = 5'b11000;
   localparam logic [4:0] c_stall = 5'b00010;
   localparam logic [4:0] c_flush = 5'b11110;
   localparam logic [4:0] c_busy  = 5'b00001;
   localparam logic [4:0] c_rst   = 5'b00010;

   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses_rt;
      logic       mem_read;
      logic [4:0] ex_rt;
      logic       br;
      logic       busy;
      logic [4:0] exp_out;
      logic [1:0] exp_state;
      int         exp_stall;
      int         exp_flush;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                               input logic mr, input logic [4:0] er, input logic br,
                               input logic busy, input logic [4:0] eo, input logic [1:0] es,
                               input int estall, input int eflush);
      vec_t v;
      v.rs = rs; v.rt = rt; v.uses_rt = uses; v.mem_read = mr; v.ex_rt = er;
      v.br = br; v.busy = busy; v.exp_out = eo; v.exp_state = es;
      v.exp_stall = estall; v.exp_flush = eflush;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic int outs();
      return int'({pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze});
   endfunction

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                        input logic mr, input logic [4:0] er, input logic br, input logic busy);
      id_rs = rs; id_rt = rt; id_uses_rt = uses; ex_mem_read = mr;
      ex_rt = er; branch_taken = br; mem_busy = busy;
   endtask

   // Called just after a falling edge: check Mealy outputs mid-cycle, then
   // registered results just after the rising edge, and return to a falling edge.
   task automatic step(input string name, input logic [4:0] eo, input logic [1:0] es,
                       input int estall, input int eflush);
      #1;
      check({name, ".outs"}, outs(), int'(eo));
      @(posedge clock);
      #1;
      check({name, ".state"}, int'(state), int'(es));
      check({name, ".stall_count"}, int'(stall_count), estall);
      check({name, ".flush_count"}, int'(flush_count), eflush);
      @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      // idle, load-use via rs, masked in STALL, register zero, rt gating
      vecs[0]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, c_def,   2'd0, 0, 0);
      vecs[1]  = mk(5'd8, 5'd0, 0, 1, 5'd8, 0, 0, c_stall, 2'd1, 1, 0);
      vecs[2]  = mk(5'd8, 5'd0, 0, 1, 5'd8, 0, 0, c_def,   2'd0, 1, 0);
      vecs[3]  = mk(5'd0, 5'd0, 0, 1, 5'd0, 0, 0, c_def,   2'd0, 1, 0);
      vecs[4]  = mk(5'd1, 5'd9, 0, 1, 5'd9, 0, 0, c_def,   2'd0, 1, 0);
      vecs[5]  = mk(5'd1, 5'd9, 1, 1, 5'd9, 0, 0, c_stall, 2'd1, 2, 0);
      // branch from STALL, ignored in FLUSH, branch beats load-use in RUN
      vecs[6]  = mk(5'd1, 5'd9, 1, 1, 5'd9, 1, 0, c_flush, 2'd2, 2, 1);
      vecs[7]  = mk(5'd8, 5'd0, 0, 1, 5'd8, 1, 0, c_def,   2'd0, 2, 1);
      vecs[8]  = mk(5'd8, 5'd0, 0, 1, 5'd8, 1, 0, c_flush, 2'd2, 2, 2);
      vecs[9]  = mk(5'd8, 5'd0, 0, 1, 5'd8, 1, 0, c_def,   2'd0, 2, 2);
      // memory hold over a pending load-use, then the stall on release
      vecs[10] = mk(5'd8, 5'd0, 0, 1, 5'd8, 0, 1, c_busy,  2'd0, 2, 2);
      vecs[11] = mk(5'd8, 5'd0, 0, 1, 5'd8, 0, 1, c_busy,  2'd0, 2, 2);
      vecs[12] = mk(5'd8, 5'd0, 0, 1, 5'd8, 1, 1, c_busy,  2'd0, 2, 2);
      vecs[13] = mk(5'd8, 5'd0, 0, 1, 5'd8, 0, 0, c_stall, 2'd1, 3, 2);
      vecs[14] = mk(5'd8, 5'd0, 0, 1, 5'd8, 1, 1, c_busy,  2'd1, 3, 2);
      vecs[15] = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, c_def,   2'd0, 3, 2);

      // Reset is asserted from time 0: outputs and state during reset
      #2;
      check("reset.outs", outs(), int'(c_rst));
      check("reset.state", int'(state), 0);
      check("reset.stall_count", int'(stall_count), 0);
      check("reset.flush_count", int'(flush_count), 0);
      do_reset();

      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].mem_read,
               vecs[i].ex_rt, vecs[i].br, vecs[i].busy);
         step($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_state,
              vecs[i].exp_stall, vecs[i].exp_flush);
      end

      // Fresh start: simultaneous branch + load-use, then branch ignored in FLUSH
      do_reset();
      drive(5'd8, 5'd0, 0, 1, 5'd8, 1, 0);
      step("simul", c_flush, 2'd2, 0, 1);
      step("simul_next", c_def, 2'd0, 0, 1);

      // Continuous load-use: one stall per two cycles; 2-bit counter saturates
      do_reset();
      drive(5'd4, 5'd0, 0, 1, 5'd4, 0, 0);
      for (int k = 0; k < 10; k++) begin
         @(posedge clock);
      end
      @(negedge clock);
      check("sat.wide_stall_count", int'(stall_count), 5);
      check("sat.narrow_stall_count", int'(s_stall_count), 3);
      check("sat.narrow_flush_count", int'(s_flush_count), 0);

      // Asynchronous reset in the middle of a STALL cycle
      do_reset();
      drive(5'd4, 5'd0, 0, 1, 5'd4, 0, 0);
      step("pre_abort", c_stall, 2'd1, 1, 0);
      #2;
      reset_n = 1'b0;
      #1;
      check("abort.state", int'(state), 0);
      check("abort.stall_count", int'(stall_count), 0);
      check("abort.outs", outs(), int'(c_rst));
      @(negedge clock);
      reset_n = 1'b1;
      drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
      step("after_abort", c_def, 2'd0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/hazard_detection_unit.md
HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the event counters.
REQ-002 SHALL have parameter REG_W, default 5: width of register specifiers.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port id_rs  input  REG_W  rs specifier of the instruction in ID.
REQ-006 SHALL have port id_rt  input  REG_W  rt specifier of the instruction in ID.
REQ-007 SHALL have port id_uses_rt  input  1  ID instruction reads rt as a source.
REQ-008 SHALL have port ex_mem_read  input  1  instruction in EX is a load.
REQ-009 SHALL have port ex_rt  input  REG_W  destination of the load in EX.
REQ-010 SHALL have port branch_taken  input  1  branch/jump resolved taken in EX this cycle.
REQ-011 SHALL have port mem_busy  input  1  data memory not ready; whole pipeline must hold.
REQ-012 SHALL have port pc_write  output  1  PC load enable.
REQ-013 SHALL have port if_id_write  output  1  IF/ID register enable.
REQ-014 SHALL have port if_id_flush  output  1  clear IF/ID to NOP.
REQ-015 SHALL have port id_ex_bubble  output  1  load NOP/zero control into ID/EX.
REQ-016 SHALL have port pipe_freeze  output  1  hold ID/EX, EX/MEM, MEM/WB registers.
REQ-017 SHALL have port state  output  2  current FSM state (RUN=0, STALL=1, FLUSH=2).
REQ-018 SHALL have port stall_count  output  CNT_W  load-use stalls taken.
REQ-019 SHALL have port flush_count  output  CNT_W  branch flushes taken.

Function
REQ-020 SHALL define load_use = ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
REQ-021 SHALL produce all enable/flush/bubble outputs combinationally from state and current inputs (same-cycle effect, Mealy).
REQ-022 SHALL default, absent any event: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, pipe_freeze=0.
REQ-023 SHALL give mem_busy highest priority: pc_write=0, if_id_write=0, pipe_freeze=1, if_id_flush=0, id_ex_bubble=0; state and counters hold.
REQ-024 SHALL, in RUN with !mem_busy and branch_taken: if_id_flush=1, id_ex_bubble=1, pc_write=1; next state FLUSH; flush_count+1.
REQ-025 SHALL, in RUN with !mem_busy, !branch_taken, load_use: pc_write=0, if_id_write=0, id_ex_bubble=1; next state STALL; stall_count+1.
REQ-026 SHALL give branch_taken priority over load_use in the same cycle (load_use ignored; stall_count unchanged).
REQ-027 SHALL, in STALL, mask load_use (defaults apply), honour branch_taken as in RUN, and return to RUN otherwise; exactly one stall cycle per hazard.
REQ-028 SHALL, in FLUSH, ignore branch_taken and load_use (EX holds a squashed bubble), apply defaults, and return to RUN.
REQ-029 SHALL treat state 3 as illegal: behave as RUN and transition to RUN next cycle.
REQ-030 SHALL saturate both counters at all-ones; no wrap-around.
REQ-031 SHALL never assert if_id_flush and if_id_write=0 together.

Reset
REQ-032 SHALL, on reset_n low, immediately set state=RUN, stall_count=0, flush_count=0, independent of clock.
REQ-033 SHALL, while reset_n low, drive pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1, pipe_freeze=0.
REQ-034 SHALL abort STALL or FLUSH on reset mid-operation with no counter update; first edge after release evaluates from RUN.

Verification
REQ-035 Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 in RUN -> same cycle pc_write=0, if_id_write=0, id_ex_bubble=1; next state=1, stall_count=1; following cycle defaults, state=0.
REQ-036 Register zero: ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall, defaults, stall_count unchanged.
REQ-037 rt gating: ex_rt=9, id_rt=9, id_uses_rt=0 -> no stall; id_uses_rt=1 -> stall.
REQ-038 Simultaneous: branch_taken=1 with load_use=1 -> if_id_flush=1, id_ex_bubble=1, pc_write=1; state=2, flush_count=1, stall_count=0; branch_taken=1 next cycle ignored.
REQ-039 Memory hold: mem_busy=1 for 3 cycles during load_use -> pipe_freeze=1, no counter change, state=0; on release stall taken, stall_count=1.
REQ-040 Saturation/reset: CNT_W=2, 5 stalls -> stall_count=3; reset_n low while state=1 -> state=0, counters 0 asynchronously.
